// File: rtl/ccw_output_if.sv
// Link-side and requester-side signals of the counter-clockwise ring output port.
// The slave modport is the output port itself; master is the requesters plus the downstream link.
interface ccw_output_if #(
  parameter int DATA_WIDTH = 64
);

  logic                  polarity;
  logic                  req_ccw_even;
  logic                  req_ccw_odd;
  logic                  req_pe_even;
  logic                  req_pe_odd;
  logic [DATA_WIDTH-1:0] din_ccw_even;
  logic [DATA_WIDTH-1:0] din_ccw_odd;
  logic [DATA_WIDTH-1:0] din_pe_even;
  logic [DATA_WIDTH-1:0] din_pe_odd;
  logic                  gnt_ccw_even;
  logic                  gnt_ccw_odd;
  logic                  gnt_pe_even;
  logic                  gnt_pe_odd;
  logic                  ccwro;
  logic                  ccwso;
  logic [DATA_WIDTH-1:0] ccwdo;

  modport slave (
    input  polarity,
    input  req_ccw_even, req_ccw_odd, req_pe_even, req_pe_odd,
    input  din_ccw_even, din_ccw_odd, din_pe_even, din_pe_odd,
    output gnt_ccw_even, gnt_ccw_odd, gnt_pe_even, gnt_pe_odd,
    input  ccwro,
    output ccwso, ccwdo
  );

  modport master (
    output polarity,
    output req_ccw_even, req_ccw_odd, req_pe_even, req_pe_odd,
    output din_ccw_even, din_ccw_odd, din_pe_even, din_pe_odd,
    input  gnt_ccw_even, gnt_ccw_odd, gnt_pe_even, gnt_pe_odd,
    output ccwro,
    input  ccwso, ccwdo
  );

endinterface

// File: rtl/ccw_output.sv
// Counter-clockwise ring transmit port: per-VC round-robin arbitration, one-packet buffer per VC,
// hop decrement on send. Define CCW_OUT_STATS_EN to add the per-VC sent-packet counters.
module ccw_output #(
  parameter int DATA_WIDTH = 64,
  parameter int HOP_MSB    = 55,
  parameter int HOP_LSB    = 48
`ifdef CCW_OUT_STATS_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  ccw_output_if.slave          bus
`ifdef CCW_OUT_STATS_EN
  , output logic [CNT_WIDTH-1:0] sent_even_cnt,
  output logic [CNT_WIDTH-1:0]   sent_odd_cnt
`endif
);

  localparam int HOP_W = HOP_MSB - HOP_LSB + 1;
  localparam logic [HOP_W-1:0] HOP_ONE = HOP_W'(1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } vcState_e;

  // Index 0 is the even VC, index 1 the odd VC throughout.
  vcState_e              state_q [2];
  logic [DATA_WIDTH-1:0] buf_q   [2];
  logic [1:0]            rr_q;

  logic [1:0]            reqCcw;
  logic [1:0]            reqPe;
  logic [1:0]            gntCcw;
  logic [1:0]            gntPe;
  logic [DATA_WIDTH-1:0] dinCcw [2];
  logic [DATA_WIDTH-1:0] dinPe  [2];

  logic                  sendVc;
  logic                  sendNow;
  logic [DATA_WIDTH-1:0] sendBuf;
  logic [HOP_W-1:0]      sendHop;
  logic [HOP_W-1:0]      sendHopDec;
  logic [DATA_WIDTH-1:0] sendData;

  assign reqCcw    = {bus.req_ccw_odd, bus.req_ccw_even};
  assign reqPe     = {bus.req_pe_odd,  bus.req_pe_even};
  assign dinCcw[0] = bus.din_ccw_even;
  assign dinCcw[1] = bus.din_ccw_odd;
  assign dinPe[0]  = bus.din_pe_even;
  assign dinPe[1]  = bus.din_pe_odd;

  // A full VC never grants, even when it drains this cycle, so each VC moves at most one packet per two cycles.
  always_comb begin
    gntCcw = '0;
    gntPe  = '0;
    for (int v = 0; v < 2; v++) begin
      if (rst && state_q[v] == EMPTY) begin
        if (reqCcw[v] && reqPe[v]) begin
          gntCcw[v] = ~rr_q[v];
          gntPe[v]  = rr_q[v];
        end else begin
          gntCcw[v] = reqCcw[v];
          gntPe[v]  = reqPe[v];
        end
      end
    end
  end

  assign bus.gnt_ccw_even = gntCcw[0];
  assign bus.gnt_ccw_odd  = gntCcw[1];
  assign bus.gnt_pe_even  = gntPe[0];
  assign bus.gnt_pe_odd   = gntPe[1];

  // The hop field saturates at zero rather than wrapping.
  always_comb begin
    sendVc     = bus.polarity;
    sendBuf    = buf_q[sendVc];
    sendHop    = sendBuf[HOP_MSB:HOP_LSB];
    sendHopDec = (sendHop == '0) ? '0 : sendHop - HOP_ONE;
    sendNow    = (state_q[sendVc] == FULL) & bus.ccwro & rst;
    sendData   = '0;
    if (sendNow) begin
      sendData                  = sendBuf;
      sendData[HOP_MSB:HOP_LSB] = sendHopDec;
    end
  end

  assign bus.ccwso = sendNow;
  assign bus.ccwdo = sendData;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int v = 0; v < 2; v++) begin
        state_q[v] <= EMPTY;
        buf_q[v]   <= '0;
      end
      rr_q <= '0;
    end else begin
      for (int v = 0; v < 2; v++) begin
        case (state_q[v])
          EMPTY: begin
            if (gntCcw[v] || gntPe[v]) begin
              buf_q[v]   <= gntCcw[v] ? dinCcw[v] : dinPe[v];
              state_q[v] <= FULL;
              if (reqCcw[v] && reqPe[v]) begin
                rr_q[v] <= gntCcw[v];
              end
            end
          end
          FULL: begin
            if (sendNow && sendVc == 1'(v)) begin
              state_q[v] <= EMPTY;
            end
          end
          default: state_q[v] <= EMPTY;
        endcase
      end
    end
  end

`ifdef CCW_OUT_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] sentCnt_q [2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      sentCnt_q[0] <= '0;
      sentCnt_q[1] <= '0;
    end else if (sendNow && sentCnt_q[sendVc] != '1) begin
      sentCnt_q[sendVc] <= sentCnt_q[sendVc] + CNT_ONE;
    end
  end

  assign sent_even_cnt = sentCnt_q[0];
  assign sent_odd_cnt  = sentCnt_q[1];
`endif

endmodule
